// File: rtl/alarm_sequencer.sv
// Alarm panel sequencer: two motion sensors, a door contact and a 5-key pad drive
// an arming FSM with exit/entry delays, siren timeout, wrong-code lockout and alarm memory.
module alarm_sequencer #(
  parameter logic [4:0] ARM_CODE    = 5'b10000,
  parameter logic [4:0] DISARM_CODE = 5'b00100,
  parameter int         EXIT_DLY    = 16,
  parameter int         ENTRY_DLY   = 32,
  parameter int         SIREN_TIME  = 64,
  parameter int         MAX_TRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1,
  input  logic       m2,
  input  logic       r,
  input  logic [4:0] k,
  output logic       active,
  output logic       alarm,
  output logic       beep,
  output logic       alarm_mem,
  output logic [2:0] state
);

  localparam int DLY_A   = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int DLY_MAX = (DLY_A > SIREN_TIME) ? DLY_A : SIREN_TIME;
  localparam int TW      = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int BW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_DLY - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DLY - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_TIME - 1);
  localparam logic [BW-1:0] LAST_TRY   = BW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          mem_q, mem_d;
  logic          active_q, alarm_q, beep_q;

  // Synchronizer bit order: {m1, m2, r, k[4:0]}
  logic [7:0]    sync1_q, sync2_q;
  logic [4:0]    k_prev_q;

  logic [4:0]    k_s;
  logic          m1_s, m2_s, r_s;
  logic          key_evt, arm_evt, disarm_evt, wrong_evt;

  assign k_s  = sync2_q[4:0];
  assign r_s  = sync2_q[5];
  assign m2_s = sync2_q[6];
  assign m1_s = sync2_q[7];

  // A key event is a change to a non-zero code, so a held key is seen once.
  assign key_evt    = (k_s != k_prev_q) && (k_s != 5'd0);
  assign arm_evt    = key_evt && (k_s == ARM_CODE);
  assign disarm_evt = key_evt && (k_s == DISARM_CODE);
  assign wrong_evt  = key_evt && (k_s != ARM_CODE) && (k_s != DISARM_CODE);

  // NOTE: every variable below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    bad_d   = bad_q;
    mem_d   = mem_q;

    case (state_q)
      ST_DISARMED: begin
        if (arm_evt) begin
          state_d = ST_EXIT;
          timer_d = EXIT_LOAD;
          bad_d   = '0;
        end
      end

      ST_EXIT, ST_ARMED, ST_ENTRY, ST_ALARM: begin
        if (disarm_evt) begin
          state_d = ST_DISARMED;
          timer_d = '0;
          bad_d   = '0;
          mem_d   = 1'b0;
        end else if (wrong_evt && (bad_q >= LAST_TRY)) begin
          state_d = ST_ALARM;
          timer_d = SIREN_LOAD;
          bad_d   = '0;
          mem_d   = 1'b1;
        end else begin
          if (wrong_evt) begin
            bad_d = bad_q + BW'(1);
          end
          case (state_q)
            ST_EXIT: begin
              if (timer_q == '0) begin
                state_d = ST_ARMED;
              end
            end
            ST_ARMED: begin
              if (m1_s || m2_s) begin
                state_d = ST_ALARM;
                timer_d = SIREN_LOAD;
                mem_d   = 1'b1;
              end else if (r_s) begin
                state_d = ST_ENTRY;
                timer_d = ENTRY_LOAD;
              end
            end
            ST_ENTRY: begin
              if (timer_q == '0) begin
                state_d = ST_ALARM;
                timer_d = SIREN_LOAD;
                mem_d   = 1'b1;
              end
            end
            ST_ALARM: begin
              // Siren timeout re-arms; alarm memory survives until a disarm.
              if (timer_q == '0) begin
                state_d = ST_ARMED;
              end
            end
            default: begin
              state_d = ST_DISARMED;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_DISARMED;
        timer_d = '0;
        bad_d   = '0;
        mem_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_DISARMED;
      timer_q  <= '0;
      bad_q    <= '0;
      mem_q    <= 1'b0;
      active_q <= 1'b0;
      alarm_q  <= 1'b0;
      beep_q   <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      k_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bad_q    <= bad_d;
      mem_q    <= mem_d;
      active_q <= (state_d != ST_DISARMED);
      alarm_q  <= (state_d == ST_ALARM);
      beep_q   <= (state_d == ST_EXIT) || (state_d == ST_ENTRY);
      sync1_q  <= {m1, m2, r, k};
      sync2_q  <= sync1_q;
      k_prev_q <= k_s;
    end
  end

  assign active    = active_q;
  assign alarm     = alarm_q;
  assign beep      = beep_q;
  assign alarm_mem = mem_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with short delays (exit 4, entry 6, siren 8, 3 tries).
module tb_alarm_sequencer;

  localparam logic [4:0] ARM = 5'b10000;
  localparam logic [4:0] DIS = 5'b00100;

  logic       clk = 1'b0;
  logic       rst;
  logic       m1, m2, r;
  logic [4:0] k;
  logic       active, alarm, beep, alarm_mem;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_sequencer #(
    .ARM_CODE    (ARM),
    .DISARM_CODE (DIS),
    .EXIT_DLY    (4),
    .ENTRY_DLY   (6),
    .SIREN_TIME  (8),
    .MAX_TRIES   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m1        (m1),
    .m2        (m2),
    .r         (r),
    .k         (k),
    .active    (active),
    .alarm     (alarm),
    .beep      (beep),
    .alarm_mem (alarm_mem),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns in cycle 7 after the arm code was applied: state must be ARMED.
  task automatic arm();
    k = ARM; tick(1); k = 5'd0; tick(6);
    check("arm_armed", state, 3'd2);
  endtask

  task automatic disarm();
    k = DIS; tick(1); k = 5'd0; tick(2);
    check("disarm_state", state, 3'd0);
    check("disarm_mem", alarm_mem, 1'b0);
  endtask

  initial begin
    rst = 1'b1; m1 = 1'b0; m2 = 1'b0; r = 1'b0; k = 5'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_state", state, 3'd0);
    check("rst_active", active, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_beep", beep, 1'b0);
    check("rst_mem", alarm_mem, 1'b0);

    // Arm: code at cycle 0, exit delay cycles 3..6, ARMED at 7.
    k = ARM; tick(1); k = 5'd0; tick(1);
    check("arm_c2_active", active, 1'b0);
    tick(1);
    check("arm_c3_active", active, 1'b1);
    check("arm_c3_beep", beep, 1'b1);
    check("arm_c3_state", state, 3'd1);
    tick(3);
    check("arm_c6_state", state, 3'd1);
    tick(1);
    check("arm_c7_state", state, 3'd2);
    check("arm_c7_beep", beep, 1'b0);
    check("arm_c7_active", active, 1'b1);

    // Motion trip: alarm t+3..t+10, ARMED at t+11 with memory held.
    m2 = 1'b1; tick(1); m2 = 1'b0; tick(1);
    check("trip_c2_alarm", alarm, 1'b0);
    tick(1);
    check("trip_c3_alarm", alarm, 1'b1);
    check("trip_c3_mem", alarm_mem, 1'b1);
    check("trip_c3_state", state, 3'd4);
    tick(7);
    check("trip_c10_alarm", alarm, 1'b1);
    tick(1);
    check("trip_c11_state", state, 3'd2);
    check("trip_c11_alarm", alarm, 1'b0);
    check("trip_c11_mem", alarm_mem, 1'b1);
    disarm();
    check("disarm_active", active, 1'b0);

    // Entry delay cancelled by disarm code at t+5.
    arm();
    r = 1'b1; tick(1); r = 1'b0; tick(2);
    check("entry_c3_state", state, 3'd3);
    check("entry_c3_beep", beep, 1'b1);
    tick(2);
    k = DIS; tick(1); k = 5'd0; tick(1);
    check("entry_c7_state", state, 3'd3);
    check("entry_c7_alarm", alarm, 1'b0);
    tick(1);
    check("entry_c8_state", state, 3'd0);
    check("entry_c8_alarm", alarm, 1'b0);
    check("entry_c8_mem", alarm_mem, 1'b0);

    // Entry delay expires: alarm at t+9.
    arm();
    r = 1'b1; tick(1); r = 1'b0; tick(7);
    check("entryx_c8_state", state, 3'd3);
    check("entryx_c8_alarm", alarm, 1'b0);
    tick(1);
    check("entryx_c9_alarm", alarm, 1'b1);
    check("entryx_c9_beep", beep, 1'b0);
    disarm();

    // Three separate wrong codes: third seen at c0+6, ALARM at c0+7.
    arm();
    k = 5'b00001; tick(1);
    k = 5'b00000; tick(1);
    k = 5'b00010; tick(1);
    k = 5'b00000; tick(1);
    k = 5'b01000; tick(1);
    k = 5'b00000; tick(1);
    check("wrong_c6_state", state, 3'd2);
    tick(1);
    check("wrong_c7_state", state, 3'd4);
    check("wrong_c7_alarm", alarm, 1'b1);
    check("wrong_c7_mem", alarm_mem, 1'b1);
    disarm();

    // Held wrong code counts once; arm code while armed is not counted.
    arm();
    k = 5'b00001; tick(10); k = 5'd0; tick(3);
    check("hold_state", state, 3'd2);
    k = ARM; tick(1); k = 5'd0; tick(3);
    check("armkey_state", state, 3'd2);
    k = 5'b00010; tick(1); k = 5'd0; tick(3);
    check("hold_2nd_state", state, 3'd2);
    k = 5'b01000; tick(1); k = 5'd0; tick(2);
    check("hold_3rd_state", state, 3'd4);
    disarm();

    // Wrong codes while disarmed are ignored.
    k = 5'b00001; tick(1); k = 5'd0; tick(1);
    k = 5'b00010; tick(1); k = 5'd0; tick(1);
    k = 5'b01000; tick(1); k = 5'd0; tick(3);
    check("dis_wrong_state", state, 3'd0);
    check("dis_wrong_alarm", alarm, 1'b0);

    // Motion and disarm in the same cycle: disarm wins.
    arm();
    m1 = 1'b1; k = DIS; tick(1); m1 = 1'b0; k = 5'd0; tick(2);
    check("simul_state", state, 3'd0);
    check("simul_alarm", alarm, 1'b0);
    check("simul_mem", alarm_mem, 1'b0);
    tick(2);
    check("simul_later_alarm", alarm, 1'b0);

    // Held motion re-trips one cycle after the siren times out.
    arm();
    m1 = 1'b1; tick(3);
    check("retrip_c3_state", state, 3'd4);
    tick(8);
    check("retrip_c11_state", state, 3'd2);
    check("retrip_c11_alarm", alarm, 1'b0);
    tick(1);
    check("retrip_c12_state", state, 3'd4);
    check("retrip_c12_alarm", alarm, 1'b1);
    m1 = 1'b0;
    disarm();

    // Reset mid-siren clears everything on the next edge.
    arm();
    m1 = 1'b1; tick(1); m1 = 1'b0; tick(2);
    check("rsiren_alarm", alarm, 1'b1);
    tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rsiren_state", state, 3'd0);
    check("rsiren_active", active, 1'b0);
    check("rsiren_alarm0", alarm, 1'b0);
    check("rsiren_beep", beep, 1'b0);
    check("rsiren_mem", alarm_mem, 1'b0);
    arm();
    check("rearm_active", active, 1'b1);
    check("rearm_mem", alarm_mem, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
